// File: rtl/serial_mult_unit.sv
// Serial shift-add multiplier / multiply-accumulator with push-button nibble entry.
// Define SERIAL_MULT_DEBOUNCE_EN to build the debouncer on the synchronised load button.
module serial_mult_unit #(
    parameter int unsigned OPW       = 8,
    parameter int unsigned NIB_W     = 4,
    parameter int unsigned DB_CYCLES = 256,
    localparam int unsigned NBYTES   = (2 * OPW) / 8,
    localparam int unsigned BSW      = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NIB_W-1:0] data_in,
    input  logic             valid,
    input  logic             mode,
    input  logic             clr_acc,
    input  logic [BSW-1:0]   byte_sel,
    output logic [7:0]       data_out,
    output logic             busy,
    output logic             done
);

    localparam int unsigned PW   = 2 * OPW;
    localparam int unsigned NGRP = PW / NIB_W;
    localparam int unsigned LCW  = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam int unsigned SCW  = (OPW > 1) ? $clog2(OPW) : 1;

    if ((OPW % NIB_W) != 0 || (PW % 8) != 0 || DB_CYCLES == 0) begin : g_param_check
        $error("serial_mult_unit: illegal parameter combination");
    end

    typedef enum logic {
        StIdle,
        StMult
    } state_e;

    // Button synchroniser
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic valid_db;

    always_comb begin
        sync1_d = valid;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

`ifdef SERIAL_MULT_DEBOUNCE_EN
    localparam int unsigned DBW = $clog2(DB_CYCLES + 1);

    logic [DBW-1:0] db_cnt_q, db_cnt_d;
    logic           valid_db_q, valid_db_d;

    // Counter only advances while the synchronised level disagrees with the filtered one.
    always_comb begin
        db_cnt_d   = '0;
        valid_db_d = valid_db_q;
        if (sync2_q != valid_db_q) begin
            if (db_cnt_q == DBW'(DB_CYCLES - 1)) begin
                valid_db_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            db_cnt_q   <= '0;
            valid_db_q <= 1'b0;
        end else begin
            db_cnt_q   <= db_cnt_d;
            valid_db_q <= valid_db_d;
        end
    end

    assign valid_db = valid_db_q;
`else
    assign valid_db = sync2_q;
`endif

    // Rising-edge detect of the filtered button
    logic vdb_prev_q, vdb_prev_d;
    logic load_pulse;

    always_comb begin
        vdb_prev_d = valid_db;
        load_pulse = valid_db & ~vdb_prev_q;
    end

    // Operand entry
    logic [PW-1:0]  operand_q, operand_d;
    logic [LCW-1:0] ld_cnt_q, ld_cnt_d;
    logic           start;
    state_e         state_q, state_d;

    always_comb begin
        operand_d = operand_q;
        ld_cnt_d  = ld_cnt_q;
        start     = 1'b0;
        if (load_pulse && (state_q == StIdle)) begin
            operand_d = {operand_q[PW-NIB_W-1:0], data_in};
            if (ld_cnt_q == LCW'(NGRP - 1)) begin
                ld_cnt_d = '0;
                start    = 1'b1;
            end else begin
                ld_cnt_d = ld_cnt_q + 1'b1;
            end
        end
    end

    // Shift-add datapath and control
    logic [PW-1:0]  mcand_q, mcand_d;
    logic [OPW-1:0] mplier_q, mplier_d;
    logic [PW-1:0]  acc_q, acc_d;
    logic [SCW-1:0] step_q, step_d;
    logic           mode_q, mode_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        step_d   = step_q;
        mode_d   = mode_q;
        unique case (state_q)
            StIdle: begin
                // Operands come from operand_d so the final group is already included.
                if (start) begin
                    state_d  = StMult;
                    busy_d   = 1'b1;
                    mcand_d  = {{OPW{1'b0}}, operand_d[PW-1:OPW]};
                    mplier_d = operand_d[OPW-1:0];
                    acc_d    = '0;
                    step_d   = '0;
                    mode_d   = mode;
                end
            end
            StMult: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                step_d   = step_q + 1'b1;
                if (step_q == SCW'(OPW - 1)) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Result register: written during the done cycle, clr_acc forces a zero base
    logic [PW-1:0] result_q, result_d;
    logic [PW-1:0] base;

    always_comb begin
        base     = clr_acc ? '0 : result_q;
        result_d = base;
        if (done_q) begin
            result_d = mode_q ? (base + acc_q) : acc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vdb_prev_q <= 1'b0;
            operand_q  <= '0;
            ld_cnt_q   <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            step_q     <= '0;
            mode_q     <= 1'b0;
            result_q   <= '0;
        end else begin
            vdb_prev_q <= vdb_prev_d;
            operand_q  <= operand_d;
            ld_cnt_q   <= ld_cnt_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            acc_q      <= acc_d;
            step_q     <= step_d;
            mode_q     <= mode_d;
            result_q   <= result_d;
        end
    end

    // Byte select; unmatched codes leave the output at zero
    always_comb begin
        data_out = '0;
        for (int unsigned i = 0; i < NBYTES; i++) begin
            if (byte_sel == BSW'(i)) begin
                data_out = result_q[8*i +: 8];
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_serial_mult_unit.sv
// Bench for serial_mult_unit: table of multiply/MAC runs plus hand-written sequences for
// loads while busy, reset mid-multiply, clr_acc during done and (optionally) debounce.
module tb_serial_mult_unit;

    localparam int unsigned OPW       = 8;
    localparam int unsigned NIB_W     = 4;
    localparam int unsigned DB_CYCLES = 256;
`ifdef SERIAL_MULT_DEBOUNCE_EN
    localparam int unsigned HOLD = DB_CYCLES + 4;
`else
    localparam int unsigned HOLD = 4;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic [NIB_W-1:0] data_in;
    logic             valid;
    logic             mode;
    logic             clr_acc;
    logic [0:0]       byte_sel;
    logic [7:0]       data_out;
    logic             busy;
    logic             done;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned busy_cnt = 0;
    int unsigned done_cnt = 0;

    serial_mult_unit #(
        .OPW       (OPW),
        .NIB_W     (NIB_W),
        .DB_CYCLES (DB_CYCLES)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .valid    (valid),
        .mode     (mode),
        .clr_acc  (clr_acc),
        .byte_sel (byte_sel),
        .data_out (data_out),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (busy) busy_cnt <= busy_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    typedef struct {
        string       name;
        logic        clr;
        logic        m;
        logic [15:0] nibs;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[6];

    task automatic step(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic load(input logic [NIB_W-1:0] nib);
        valid = 1'b0;
        step(HOLD);
        data_in = nib;
        valid   = 1'b1;
        step(HOLD);
        valid = 1'b0;
    endtask

    task automatic run_seq(input logic [15:0] nibs, input logic m);
        mode = m;
        for (int i = 3; i >= 0; i--) load(nibs[4*i +: 4]);
    endtask

    task automatic wait_done(input int unsigned d0);
        int unsigned n = 0;
        while (done_cnt == d0 && n < 100) begin
            step(1);
            n++;
        end
        step(2);
    endtask

    task automatic pulse_clr();
        clr_acc = 1'b1;
        step(1);
        clr_acc = 1'b0;
    endtask

    task automatic check_result(input string name, input logic [15:0] exp);
        byte_sel = 1'b0;
        #1;
        check({name, " byte0"}, 32'(data_out), 32'(exp[7:0]));
        byte_sel = 1'b1;
        #1;
        check({name, " byte1"}, 32'(data_out), 32'(exp[15:8]));
        byte_sel = 1'b0;
    endtask

    initial begin
        int unsigned b0;
        int unsigned d0;
        int unsigned n;

        vecs[0] = '{name: "mul 1203",   clr: 1'b1, m: 1'b0, nibs: 16'h1203, exp: 16'h0036};
        vecs[1] = '{name: "mul FFFF",   clr: 1'b0, m: 1'b0, nibs: 16'hFFFF, exp: 16'hFE01};
        vecs[2] = '{name: "mac1 1203",  clr: 1'b1, m: 1'b1, nibs: 16'h1203, exp: 16'h0036};
        vecs[3] = '{name: "mac2 1203",  clr: 1'b0, m: 1'b1, nibs: 16'h1203, exp: 16'h006C};
        vecs[4] = '{name: "mac1 FFFF",  clr: 1'b1, m: 1'b1, nibs: 16'hFFFF, exp: 16'hFE01};
        vecs[5] = '{name: "mac2 wrap",  clr: 1'b0, m: 1'b1, nibs: 16'hFFFF, exp: 16'hFC02};

        reset    = 1'b1;
        data_in  = '0;
        valid    = 1'b0;
        mode     = 1'b0;
        clr_acc  = 1'b0;
        byte_sel = 1'b0;
        step(3);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check_result("reset result", 16'h0000);
        reset = 1'b0;
        step(2);

        for (int k = 0; k < 6; k++) begin
            if (vecs[k].clr) pulse_clr();
            b0 = busy_cnt;
            d0 = done_cnt;
            run_seq(vecs[k].nibs, vecs[k].m);
            wait_done(d0);
            check({vecs[k].name, " busy cycles"}, 32'(busy_cnt - b0), 32'd8);
            check({vecs[k].name, " done pulses"}, 32'(done_cnt - d0), 32'd1);
            check_result(vecs[k].name, vecs[k].exp);
        end

        // clr_acc during the done cycle: base taken as zero (result holds 0xFC02 here)
        run_seq(16'h1203, 1'b1);
        n = 0;
        while (!done && n < 100) begin
            step(1);
            n++;
        end
        check("clr@done saw done", 32'(done), 32'd1);
        pulse_clr();
        step(1);
        check_result("clr@done", 16'h0036);

        // Extra button press while busy must be dropped
        b0 = busy_cnt;
        d0 = done_cnt;
        run_seq(16'h1203, 1'b0);
        step(2);
        data_in = 4'hA;
        valid   = 1'b1;
        step(2);
        valid = 1'b0;
        wait_done(d0);
        check("busy-load busy cycles", 32'(busy_cnt - b0), 32'd8);
        check_result("busy-load", 16'h0036);
        d0 = done_cnt;
        run_seq(16'h2005, 1'b0);
        wait_done(d0);
        check_result("after busy-load", 16'h00A0);

        // Reset mid-multiply aborts with no done and clears result
        run_seq(16'hFFFF, 1'b0);
        n = 0;
        while (!busy && n < 50) begin
            step(1);
            n++;
        end
        check("abort busy seen", 32'(busy), 32'd1);
        step(3);
        d0 = done_cnt;
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(20);
        check("abort done pulses", 32'(done_cnt - d0), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check_result("abort result", 16'h0000);
        d0 = done_cnt;
        run_seq(16'h1203, 1'b0);
        wait_done(d0);
        check_result("post-abort", 16'h0036);

`ifdef SERIAL_MULT_DEBOUNCE_EN
        begin
            int unsigned npulse = 0;
            int unsigned at = 0;
            valid = 1'b0;
            step(HOLD);
            for (int g = 0; g < 3; g++) begin
                valid = 1'b1;
                step(10);
                valid = 1'b0;
                step(10);
            end
            valid = 1'b1;
            for (int j = 1; j <= 300; j++) begin
                step(1);
                if (dut.load_pulse) begin
                    npulse++;
                    at = j;
                end
            end
            valid = 1'b0;
            check("debounce pulse count", 32'(npulse), 32'd1);
            // Two synchroniser cycles, then DB_CYCLES of stable mismatch
            check("debounce pulse time", 32'(at), 32'(DB_CYCLES + 2));
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_mult_unit.md
SERIAL_MULT_UNIT -- requirements
Module: serial_mult_unit

Interface
REQ-001 Parameter OPW, default 8, operand width in bits; SHALL be a multiple of NIB_W, and 2*OPW SHALL be a multiple of 8.
REQ-002 Parameter NIB_W, default 4, width of one entered data group.
REQ-003 Parameter DB_CYCLES, default 256, number of stable cycles the debouncer requires.
REQ-004 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 data_in  input  NIB_W  data group captured on each load pulse.
REQ-007 valid  input  1  asynchronous push-button load request.
REQ-008 mode  input  1  0 = multiply, 1 = multiply-accumulate; sampled at multiply start.
REQ-009 clr_acc  input  1  synchronous clear of the result register.
REQ-010 byte_sel  input  max(1,$clog2(2*OPW/8))  selects the result byte driven on data_out.
REQ-011 data_out  output  8  selected result byte, combinational from the result register.
REQ-012 busy  output  1  high while a multiply is in progress.
REQ-013 done  output  1  one-cycle pulse when the result register is written.

Function
REQ-014 valid SHALL pass through a 2-flop synchroniser before any other use.
REQ-015 The debouncer SHALL change valid_db to the synchronised level only after that level has differed from valid_db for DB_CYCLES consecutive cycles; any mismatch-free cycle SHALL reset the stability counter.
REQ-016 The load pulse SHALL be high for exactly one cycle: the cycle in which valid_db is 1 and its registered previous value is 0.
REQ-017 When idle, each load pulse SHALL shift the 2*OPW-bit operand register left by NIB_W and insert data_in at the LSBs.
REQ-018 A load counter SHALL count load pulses from 0 to 2*OPW/NIB_W-1; the load that completes the final group SHALL wrap the counter to 0 and start a multiply on the next cycle.
REQ-019 Operand A SHALL be operand[2*OPW-1:OPW] and operand B SHALL be operand[OPW-1:0], both unsigned.
REQ-020 The FSM SHALL have two states, IDLE and MULT; in MULT it SHALL perform one shift-add step per cycle for exactly OPW cycles, with busy high throughout.
REQ-021 On the cycle after the last step, the FSM SHALL return to IDLE, pulse done, and write the result register: product if the sampled mode is 0, or (result + product) mod 2^(2*OPW) if it is 1.
REQ-022 Load pulses occurring while busy is high SHALL be discarded, with no change to the operand register or the load counter.
REQ-023 clr_acc SHALL zero the result register on the next edge; if it coincides with a result write, the written value SHALL be computed with the base taken as 0.
REQ-024 data_out SHALL equal result[8*byte_sel+7 : 8*byte_sel]; out-of-range byte_sel values SHALL drive 0.
REQ-025 The operand register SHALL retain its value after a multiply; the next load sequence SHALL overwrite it group by group.

Reset
REQ-026 While reset is high, the following SHALL be cleared on every clock edge: the synchroniser, valid_db, the stability counter, the edge register, the operand register, the load counter, the multiplier datapath and the result register.
REQ-027 While reset is high, the FSM SHALL be held in IDLE, so busy = 0, done = 0 and data_out = 0.
REQ-028 A reset asserted mid-multiply SHALL abort the multiply with no result write and no done pulse.

Configuration
REQ-029 Macro SERIAL_MULT_DEBOUNCE_EN: when defined, the debouncer of REQ-015 SHALL be compiled in.
REQ-030 When SERIAL_MULT_DEBOUNCE_EN is undefined, valid_db SHALL equal the synchroniser output and the stability counter SHALL NOT be built.

Verification
REQ-031 Macro defined, defaults: 10-cycle glitches on valid, then valid held high for 300 cycles -> exactly one load pulse, occurring DB_CYCLES cycles after the synchronised rise.
REQ-032 Macro undefined, mode=0: load 1,2,0,3 -> busy high for 8 cycles, then done; result 0x0036; byte_sel=0 -> 0x36, byte_sel=1 -> 0x00.
REQ-033 mode=0: load F,F,F,F -> result 0xFE01; byte_sel=1 -> 0xFE.
REQ-034 mode=1 after clr_acc: two sequences of 1,2,0,3 -> result 0x006C; two sequences of F,F,F,F from 0 -> result 0xFC02 (wrap).
REQ-035 Load pulses issued during busy -> ignored; reset asserted at step 4 of a multiply -> no done, result 0, next sequence computes correctly.
REQ-036 clr_acc asserted in the same cycle as done with mode=1 -> result equals the product alone.
